reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/sim_pkg.sv | 15 +
 rtl/reset_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/sim_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and the halt response mode.
package sim_pkg;

  typedef enum logic [1:0] {
    SMAssert,
    SMRun,
    SMDone
  } SimState;

  typedef enum logic {
    HALT_RESTART,
    HALT_STOP
  } HaltMode;

endpackage

// File: rtl/reset_sequencer.sv
// Drives a timed reset pulse into an SoC, restarts it on halt requests (optionally
// limited), and stops on a watchdog timeout or when restarts are exhausted.
module reset_sequencer
  import sim_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 2,
  parameter int unsigned MAX_RESTARTS    = 0,
  parameter int unsigned WATCHDOG_CYCLES = 0,
  parameter HaltMode     HALT_MODE       = HALT_RESTART,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             sysClock,
  input  logic             reset,
  input  logic             halt,
  output logic             manualReset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] restart_count
);

  localparam int RST_W  = $clog2(RESET_CYCLES + 1);
  localparam int WD_RAW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 1) ? 1 : WD_RAW;

  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RESET_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_RESTARTS);
  localparam bit               WD_EN     = (WATCHDOG_CYCLES != 0);
  localparam bit               LIMITED   = (MAX_RESTARTS != 0);
  localparam bit               STOP_MODE = (HALT_MODE == HALT_STOP);

  SimState          state, state_nxt;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_nxt;
  logic [CNT_W-1:0] restart_nxt;
  logic             timeout_nxt;
  logic             halt_stops;

  // A halt ends the session instead of restarting once restarts are used up.
  assign halt_stops = STOP_MODE || (LIMITED && (restart_count == MAX_CNT));

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    wd_cnt_nxt  = wd_cnt;
    restart_nxt = restart_count;
    timeout_nxt = timeout;

    case (state)
      SMAssert: begin
        if (rst_cnt == '0) begin
          state_nxt  = SMRun;
          wd_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt - RST_W'(1);
        end
      end

      SMRun: begin
        if (halt) begin
          if (halt_stops) begin
            state_nxt = SMDone;
          end else begin
            state_nxt   = SMAssert;
            rst_cnt_nxt = RST_LOAD;
            if (restart_count != '1) begin
              restart_nxt = restart_count + CNT_W'(1);
            end
          end
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          state_nxt   = SMDone;
          timeout_nxt = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end

      SMDone: begin
        state_nxt = SMDone;
      end

      default: begin
        state_nxt = SMAssert;
      end
    endcase
  end

  // Moore outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge sysClock) begin
    if (!reset) begin
      state         <= SMAssert;
      rst_cnt       <= RST_LOAD;
      wd_cnt        <= '0;
      restart_count <= '0;
      timeout       <= 1'b0;
      manualReset   <= 1'b1;
      running       <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rst_cnt       <= rst_cnt_nxt;
      wd_cnt        <= wd_cnt_nxt;
      restart_count <= restart_nxt;
      timeout       <= timeout_nxt;
      manualReset   <= (state_nxt == SMAssert);
      running       <= (state_nxt == SMRun);
      done          <= (state_nxt == SMDone);
    end
  end

endmodule
